axis_memword_packer: RTL and testbench
======================================

Name: axis_memword_packer

Overview:
- Converts one AXI-Stream ingress (DATA_W data, TUSER_W metadata) into a stream of memory words for the SRAM output queue.
- Each packet becomes one header word carrying tuser, then data words packed to WORD_W through a byte gearbox, tagged with the destination queue.
- Parametrised successor of the fixed 256→192 converter: generic widths, N queues, drop of unaddressed packets, per-word byte count, statistics.

Parameters:
- DATA_W, 256: ingress tdata width; multiple of 8.
- TUSER_W, 128: tuser width; must be ≤ WORD_W.
- WORD_W, 192: memory-word payload width; multiple of 8.
- NUM_QUEUES, 8: number of output queues.
- DST_LSB, 24: LSB of the NUM_QUEUES-bit one-hot destination field in tuser.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- s_tvalid  in  1  ingress valid
- s_tready  out  1  ingress ready
- s_tdata  in  DATA_W  ingress data, byte 0 at LSB
- s_tstrb  in  DATA_W/8  byte enables, contiguous from LSB
- s_tuser  in  TUSER_W  metadata, sampled on first beat only
- s_tlast  in  1  end of packet
- m_valid  out  1  memory word valid
- m_ready  in  1  memory word accepted
- m_data  out  WORD_W  payload, byte 0 at LSB
- m_bytes  out  $clog2(WORD_W/8+1)  valid payload bytes; 0 on header
- m_first  out  1  header word
- m_last  out  1  final word of packet
- m_queue  out  $clog2(NUM_QUEUES)  destination queue, constant across a packet
- pkt_cnt  out  32  packets forwarded, wraps
- drop_cnt  out  32  packets dropped, wraps

Behaviour:
- Reset: state IDLE; s_tready=0, m_valid=0, m_data=0, m_bytes=0, m_first=0, m_last=0, m_queue=0, pkt_cnt=0, drop_cnt=0. Buffer byte count cnt=0; last_seen=0.
- Reset mid-packet discards all buffered data. Subsequent ingress beats are parsed as a new packet, so upstream must be reset together with this block.
- All outputs are registered.
- Once asserted, m_valid holds m_data, m_bytes, m_first, m_last and m_queue stable until m_ready.
- IDLE:
  - s_tready=0; wait for s_tvalid.
  - dst = s_tuser[DST_LSB +: NUM_QUEUES].
  - dst==0 → DROP.
  - Otherwise latch queue = index of the lowest set bit of dst and go to HDR. The header has m_valid=1 in the next cycle (latency 1), with m_data = tuser zero-extended, m_first=1, m_bytes=0.
- HDR: on m_ready → DATA. No ingress beat is consumed here; the first beat is consumed in DATA.
- DROP:
  - s_tready=1; consume beats until the tlast beat.
  - drop_cnt+1 on the tlast handshake; then → IDLE. No output words.
- DATA: residual buffer of DATA_W+WORD_W bits; cnt in bytes.
  - s_tready = (cnt ≤ WORD_W/8) && !last_seen.
  - On an accepted beat: append popcount(s_tstrb) bytes at offset cnt; set last_seen if s_tlast.
  - A word is emitted if cnt > WORD_W/8, or if last_seen && cnt > 0. The word carries the low min(cnt, WORD_W/8) bytes; the buffer shifts down by that amount on m_ready.
  - m_last=1 when last_seen and the emitted word drains cnt to 0.
  - last_seen && cnt==0 without a last word yet emitted (all-zero strobes) → emit an empty word: m_bytes=0, m_last=1.
  - Accept and emit are mutually exclusive per cycle: s_tready requires cnt ≤ WORD_W/8, which implies no full word is pending.
  - On the m_last handshake: pkt_cnt+1, clear last_seen, → IDLE.
- Exactly-full boundary: a packet ending with cnt==WORD_W/8 sends that word as full with m_last=1. There is never a trailing empty word in this case.
- Non-contiguous tstrb is a protocol violation: the byte count is the popcount, and bytes are taken from the LSB.
- Counters wrap at 2^32.

Decomposition:
- Shared package nf10_oq_pkg: state enum (IDLE, HDR, DATA, DROP), word-tag field offsets, and a byte-count width function.
- One sub-module, memword_gearbox: the residual buffer with append and shift-down, cnt, and the emit decision. The parent holds the FSM, queue decode and counters.

Test Plan:
- Addressing: tuser[31:24]=8'b10101111, 2 beats (32 B, then 20 B with tlast) → header with m_queue=0, then data words with m_bytes 24, 24, 4; m_last on the 4-byte word; pkt_cnt=1.
- Exact boundary: tuser[31:24]=8'b11101010, 32 B + 16 B tlast → m_queue=1; words 24, 24 with m_last on the second; no empty word.
- Drop: dst field = 0, 3-beat packet → s_tready=1 for 3 cycles, no m_valid, drop_cnt=1; the next valid packet is forwarded normally.
- Backpressure: hold m_ready=0 for 5 cycles during a data word → m_data and m_bytes stable, s_tready=0, no byte lost. Payload byte order verified end-to-end with an incrementing tdata pattern.
- Zero-length packet: single beat, tstrb=0, tlast=1 → header, then one word with m_bytes=0, m_last=1.
- Reset mid-packet: assert reset after the header and one data word → all outputs return to reset values next cycle; a fresh packet afterwards produces a correct header and counts.

Source files
------------

// File: rtl/nf10_oq_pkg.sv
// nf10_oq_pkg: shared FSM states and sizing helpers for the output-queue word packer
package nf10_oq_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_e;
  function automatic int cnt_w(input int bytes);
    return $clog2(bytes + 1);
  endfunction
endpackage

// File: rtl/memword_gearbox.sv
// memword_gearbox: residual byte buffer packing ingress beats into memory words
module memword_gearbox
  import nf10_oq_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int WORD_W = 192
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic [DATA_W/8-1:0]          strb_i,
  input  logic                         last_i,
  output logic [WORD_W-1:0]            word_o,
  output logic [cnt_w(WORD_W/8)-1:0]   bytes_o,
  output logic                         emit_o,
  output logic                         take_o,
  output logic                         lastw_o
);
  localparam int DB = DATA_W / 8;
  localparam int WB = WORD_W / 8;
  localparam int BUF_W = DATA_W + WORD_W;
  localparam int CW = cnt_w(DB + WB);
  localparam int OW = cnt_w(WB);
  localparam logic [CW-1:0] WBC = CW'(WB);
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d, pc, shift;
  logic last_q, last_d;
  logic [DATA_W-1:0] masked;
  // byte count of the beat and its payload with bytes above the count cleared
  always_comb begin
    pc = '0;
    masked = '0;
    for (int i = 0; i < DB; i++) pc = pc + CW'(strb_i[i]);
    for (int i = 0; i < DB; i++) masked[i*8 +: 8] = (i < int'(pc)) ? data_i[i*8 +: 8] : 8'h00;
  end
  assign shift = cnt_q > WBC ? WBC : cnt_q;
  // append at the fill level on accept, shift the emitted word out on pop
  always_comb begin
    buf_d = push_i ? buf_q | (BUF_W'(masked) << {cnt_q, 3'b000}) : pop_i ? buf_q >> {shift, 3'b000} : buf_q;
    cnt_d = push_i ? cnt_q + pc : pop_i ? cnt_q - shift : cnt_q;
    last_d = push_i ? last_q | last_i : pop_i ? last_q && cnt_q > WBC : last_q;
  end
  // buffer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      cnt_q <= '0;
      last_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  end
  assign word_o = buf_d[WORD_W-1:0];
  assign bytes_o = OW'(cnt_d > WBC ? WBC : cnt_d);
  assign emit_o = cnt_d > WBC || last_d;
  assign take_o = cnt_d <= WBC && !last_d;
  assign lastw_o = last_d && cnt_d <= WBC;
endmodule

// File: rtl/axis_memword_packer.sv
// axis_memword_packer: AXI-Stream packets to header-tagged memory words for the SRAM output queues
module axis_memword_packer
  import nf10_oq_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int TUSER_W = 128,
  parameter int WORD_W = 192,
  parameter int NUM_QUEUES = 8,
  parameter int DST_LSB = 24
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                s_tvalid,
  output logic                                s_tready,
  input  logic [DATA_W-1:0]                   s_tdata,
  input  logic [DATA_W/8-1:0]                 s_tstrb,
  input  logic [TUSER_W-1:0]                  s_tuser,
  input  logic                                s_tlast,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [WORD_W-1:0]                   m_data,
  output logic [$clog2(WORD_W/8+1)-1:0]       m_bytes,
  output logic                                m_first,
  output logic                                m_last,
  output logic [$clog2(NUM_QUEUES)-1:0]       m_queue,
  output logic [31:0]                         pkt_cnt,
  output logic [31:0]                         drop_cnt
);
  localparam int QW = $clog2(NUM_QUEUES);
  localparam int BW = cnt_w(WORD_W / 8);
  state_e state_q, state_d;
  logic s_tready_q, s_tready_d, m_valid_q, m_valid_d, m_first_q, m_first_d, m_last_q, m_last_d;
  logic [WORD_W-1:0] m_data_q, m_data_d, g_word;
  logic [BW-1:0] m_bytes_q, m_bytes_d, g_bytes;
  logic [QW-1:0] m_queue_q, m_queue_d, low;
  logic [31:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [NUM_QUEUES-1:0] dst;
  logic push, pop, g_emit, g_take, g_lastw;
  assign push = state_q == DATA && s_tvalid && s_tready_q;
  assign pop = state_q == DATA && m_valid_q && m_ready;
  memword_gearbox #(.DATA_W(DATA_W), .WORD_W(WORD_W)) u_gearbox (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .data_i(s_tdata), .strb_i(s_tstrb),
    .last_i(s_tlast), .word_o(g_word), .bytes_o(g_bytes), .emit_o(g_emit), .take_o(g_take), .lastw_o(g_lastw)
  );
  // destination decode, packet FSM and statistics
  always_comb begin
    dst = s_tuser[DST_LSB +: NUM_QUEUES];
    low = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) if (dst[i]) low = QW'(i);
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = !s_tvalid ? IDLE : dst == '0 ? DROP : HDR;
      HDR:  state_d = m_ready ? DATA : HDR;
      DROP: state_d = s_tvalid && s_tlast ? IDLE : DROP;
      DATA: state_d = m_valid_q && m_ready && m_last_q ? IDLE : DATA;
    endcase
    m_queue_d = state_q == IDLE && state_d == HDR ? low : m_queue_q;
    pkt_cnt_d = pkt_cnt_q + 32'(state_q == DATA && state_d == IDLE);
    drop_cnt_d = drop_cnt_q + 32'(state_q == DROP && state_d == IDLE);
  end
  // registered outputs derived from the next state so they change only on handshakes
  always_comb begin
    s_tready_d = state_d == DROP || (state_d == DATA && g_take);
    m_valid_d = state_d == HDR || (state_d == DATA && g_emit);
    m_data_d = state_d == HDR ? (state_q == IDLE ? WORD_W'(s_tuser) : m_data_q) : state_d == DATA ? g_word : '0;
    m_bytes_d = state_d == DATA ? g_bytes : '0;
    m_first_d = state_d == HDR;
    m_last_d = state_d == DATA && g_emit && g_lastw;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_tready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_bytes_q <= '0;
      m_first_q <= 1'b0;
      m_last_q <= 1'b0;
      m_queue_q <= '0;
      pkt_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      s_tready_q <= s_tready_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_bytes_q <= m_bytes_d;
      m_first_q <= m_first_d;
      m_last_q <= m_last_d;
      m_queue_q <= m_queue_d;
      pkt_cnt_q <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign s_tready = s_tready_q;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_bytes = m_bytes_q;
  assign m_first = m_first_q;
  assign m_last = m_last_q;
  assign m_queue = m_queue_q;
  assign pkt_cnt = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_axis_memword_packer.sv
// tb_axis_memword_packer: directed packet vectors and corner sequences for the memory word packer
module tb_axis_memword_packer;
  localparam int DW = 256;
  localparam int TW = 128;
  localparam int WW = 192;
  logic clk = 1'b0;
  logic reset, s_tvalid, s_tready, s_tlast, m_valid, m_ready, m_first, m_last;
  logic [DW-1:0] s_tdata;
  logic [DW/8-1:0] s_tstrb;
  logic [TW-1:0] s_tuser;
  logic [WW-1:0] m_data;
  logic [4:0] m_bytes;
  logic [2:0] m_queue;
  logic [31:0] pkt_cnt, drop_cnt;
  int tests = 0, fails = 0, exp_pkt = 0, exp_drop = 0;
  logic [7:0] exp_q[$];
  typedef struct packed {
    logic [7:0]      dst;
    logic [1:0]      nb;
    logic [2:0][7:0] len;
    logic [3:0]      stall;
    logic [2:0]      nw;
    logic [3:0][7:0] wb;
    logic [2:0]      q;
    logic            drop;
  } vec_t;
  vec_t vecs[7];

  axis_memword_packer dut (
    .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tuser(s_tuser), .s_tlast(s_tlast), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_bytes(m_bytes), .m_first(m_first), .m_last(m_last), .m_queue(m_queue),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tuser(input logic [7:0] d);
    return {32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678, d, 24'hABCDEF};
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_tready"}, s_tready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_bytes"}, m_bytes, 0);
    chk({tag, "_m_first"}, m_first, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_queue"}, m_queue, 0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  task automatic run(input vec_t v, input int base);
    int beat, off, w, sc, cyc, trc, idle, l;
    bit hdr, done, mv, unstable, rdy_bad, stall;
    logic [WW-1:0] snap_d, ew, mk;
    logic [4:0] snap_b;
    beat = 0; off = 0; w = 0; sc = 0; cyc = 0; trc = 0; idle = 0;
    hdr = 0; done = 0; mv = 0; unstable = 0; rdy_bad = 0;
    snap_d = '0; snap_b = '0;
    while (!done && cyc < 300) begin
      s_tvalid = beat < int'(v.nb);
      l = s_tvalid ? int'(v.len[beat]) : 0;
      s_tuser = mk_tuser(v.dst);
      s_tlast = beat == int'(v.nb) - 1;
      for (int i = 0; i < DW / 8; i++) begin
        s_tstrb[i] = i < l;
        s_tdata[i*8 +: 8] = i < l ? 8'(base + off + i) : 8'hEE;
      end
      stall = hdr && m_valid && w == int'(v.stall) && sc < 5;
      m_ready = !stall;
      if (stall) begin
        if (sc == 0) begin
          snap_d = m_data;
          snap_b = m_bytes;
        end else if (m_data !== snap_d || m_bytes !== snap_b) unstable = 1;
        if (s_tready) rdy_bad = 1;
        sc++;
      end
      if (s_tready) trc++;
      if (m_valid) mv = 1;
      if (m_valid && m_ready) begin
        if (!hdr) begin
          chk("hdr_first", m_first, 1);
          chk("hdr_bytes", m_bytes, 0);
          chk("hdr_last", m_last, 0);
          chk("hdr_data", m_data, WW'(mk_tuser(v.dst)));
          chk("hdr_queue", m_queue, v.q);
          hdr = 1;
        end else if (w >= int'(v.nw)) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got word %0d with %0d bytes, expected only %0d words", w, m_bytes, v.nw);
          done = 1;
        end else begin
          ew = '0;
          mk = '0;
          for (int i = 0; i < int'(v.wb[w]); i++) begin
            ew[i*8 +: 8] = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
            mk[i*8 +: 8] = 8'hFF;
          end
          chk($sformatf("w%0d_bytes", w), m_bytes, v.wb[w]);
          chk($sformatf("w%0d_last", w), m_last, w == int'(v.nw) - 1);
          chk($sformatf("w%0d_first", w), m_first, 0);
          chk($sformatf("w%0d_queue", w), m_queue, v.q);
          if (v.wb[w] != 0) chk($sformatf("w%0d_data", w), m_data & mk, ew);
          if (m_last) done = 1;
          w++;
        end
      end
      if (s_tvalid && s_tready) begin
        if (!v.drop) for (int i = 0; i < l; i++) exp_q.push_back(8'(base + off + i));
        off += l;
        beat++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (v.drop && beat == int'(v.nb)) idle++;
      if (idle == 4) done = 1;
    end
    s_tvalid = 0;
    m_ready = 1;
    if (!done) chk("timeout_cycles", cyc, 0);
    exp_pkt += v.drop ? 0 : 1;
    exp_drop += v.drop ? 1 : 0;
    if (v.drop) begin
      chk("drop_tready_cycles", trc, v.nb);
      chk("drop_no_m_valid", mv, 0);
    end else chk("word_count", w, v.nw);
    if (v.stall != 4'hF) begin
      chk("stall_stable", unstable, 0);
      chk("stall_tready_low", rdy_bad, 0);
      chk("stall_cycles", sc, 5);
    end
    chk("pkt_cnt", pkt_cnt, exp_pkt);
    chk("drop_cnt", drop_cnt, exp_drop);
  endtask

  initial begin
    int hs;
    vecs[0] = '{dst: 8'b10101111, nb: 2, len: {8'd0, 8'd20, 8'd32}, stall: 4'hF, nw: 3,
                wb: {8'd0, 8'd4, 8'd24, 8'd24}, q: 0, drop: 0};
    vecs[1] = '{dst: 8'b11101010, nb: 2, len: {8'd0, 8'd16, 8'd32}, stall: 4'hF, nw: 2,
                wb: {8'd0, 8'd0, 8'd24, 8'd24}, q: 1, drop: 0};
    vecs[2] = '{dst: 8'h00, nb: 3, len: {8'd10, 8'd32, 8'd32}, stall: 4'hF, nw: 0,
                wb: 32'd0, q: 0, drop: 1};
    vecs[3] = '{dst: 8'b10000000, nb: 1, len: {8'd0, 8'd0, 8'd5}, stall: 4'hF, nw: 1,
                wb: {8'd0, 8'd0, 8'd0, 8'd5}, q: 7, drop: 0};
    vecs[4] = '{dst: 8'b00000100, nb: 3, len: {8'd32, 8'd32, 8'd32}, stall: 4'd1, nw: 4,
                wb: {8'd24, 8'd24, 8'd24, 8'd24}, q: 2, drop: 0};
    vecs[5] = '{dst: 8'h10, nb: 1, len: {8'd0, 8'd0, 8'd0}, stall: 4'hF, nw: 1,
                wb: 32'd0, q: 4, drop: 0};
    vecs[6] = '{dst: 8'h40, nb: 1, len: {8'd0, 8'd0, 8'd10}, stall: 4'hF, nw: 1,
                wb: {8'd0, 8'd0, 8'd0, 8'd10}, q: 6, drop: 0};
    reset = 1; s_tvalid = 0; s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tlast = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 0;
    @(posedge clk);
    #1;
    chk("idle_s_tready", s_tready, 0);
    chk("idle_m_valid", m_valid, 0);
    for (int k = 0; k < 6; k++) run(vecs[k], k * 37);
    s_tvalid = 1; s_tuser = mk_tuser(8'h02); s_tlast = 0; s_tstrb = '1; s_tdata = {8{32'h5A5A5A5A}}; m_ready = 1;
    hs = 0;
    for (int c = 0; c < 50 && hs < 2; c++) begin
      if (m_valid && m_ready) hs++;
      @(posedge clk);
      #1;
    end
    chk("rst_mid_progress", hs, 2);
    chk("rst_mid_queue_before", m_queue, 1);
    reset = 1;
    @(posedge clk);
    #1;
    check_reset_values("rst_mid");
    reset = 0; s_tvalid = 0;
    @(posedge clk);
    #1;
    exp_pkt = 0; exp_drop = 0;
    exp_q.delete();
    run(vecs[6], 200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
